// File: rtl/add_sub_serial_ctrl.sv
// add_sub_serial_ctrl: digit-serial Y = A + B - C (mod 2^WIDTH).
// A single DIGIT-wide add/subtract slice is reused over NDIG = WIDTH/DIGIT
// cycles. The add carry and the subtract borrow are chained separately, so the
// result and flags match a parallel adder followed by a parallel subtractor.
// Optional feature macro: ADD_SUB_SERIAL_FLAGS_EN adds the Flags port,
// which carries {borrow_out, carry_out}.
module add_sub_serial_ctrl #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic             busy
`ifdef ADD_SUB_SERIAL_FLAGS_EN
  ,
  output logic [1:0]       Flags
`endif
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d, y_q, y_d;
  logic             carry_q, carry_d, borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
`ifdef ADD_SUB_SERIAL_FLAGS_EN
  logic [1:0]       flags_q, flags_d;
`endif

  logic [DIGIT:0]         sum, diff;
  logic [WIDTH+DIGIT-1:0] ycat;
  logic                   last;

  // Shared slice: add stage feeds the subtract stage. The top bit of each
  // DIGIT+1 wide result is the outgoing carry and borrow respectively.
  always_comb begin
    sum  = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
    diff = {1'b0, sum[DIGIT-1:0]} - {1'b0, c_q[DIGIT-1:0]} - {{DIGIT{1'b0}}, borrow_q};
    ycat = {diff[DIGIT-1:0], y_q};
    last = (cnt_q == CW'(NDIG - 1));
  end

  // Next-state and datapath control for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    y_d         = y_q;
    carry_d     = carry_q;
    borrow_d    = borrow_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
`ifdef ADD_SUB_SERIAL_FLAGS_EN
    flags_d     = flags_q;
`endif
    case (state_q)
      S_IDLE: begin
        // Flush outranks in_valid, so no operands are accepted in a flush cycle.
        if (!flush && in_valid) begin
          a_d      = A;
          b_d      = B;
          c_d      = C;
          carry_d  = 1'b0;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          a_d      = a_q >> DIGIT;
          b_d      = b_q >> DIGIT;
          c_d      = c_q >> DIGIT;
          carry_d  = sum[DIGIT];
          borrow_d = diff[DIGIT];
          // The result fills from the MSB side, so after NDIG digits the
          // first digit sits at the LSB end.
          y_d      = ycat[WIDTH+DIGIT-1:DIGIT];
          cnt_d    = cnt_q + CW'(1);
          if (last) begin
            state_d     = S_DONE;
            out_valid_d = 1'b1;
            cnt_d       = '0;
`ifdef ADD_SUB_SERIAL_FLAGS_EN
            flags_d     = {diff[DIGIT], sum[DIGIT]};
`endif
          end
        end
      end
      S_DONE: begin
        if (flush || out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers. Reset clears everything, including the
  // partially built result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      y_q         <= '0;
      carry_q     <= 1'b0;
      borrow_q    <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
`ifdef ADD_SUB_SERIAL_FLAGS_EN
      flags_q     <= 2'b00;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      y_q         <= y_d;
      carry_q     <= carry_d;
      borrow_q    <= borrow_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
`ifdef ADD_SUB_SERIAL_FLAGS_EN
      flags_q     <= flags_d;
`endif
    end
  end

  // in_ready and busy are decoded from the state only. in_ready is also held
  // low while reset is asserted.
  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign Y         = y_q;
`ifdef ADD_SUB_SERIAL_FLAGS_EN
  assign Flags     = flags_q;
`endif

endmodule
